// File: rtl/ballot_collector.sv
// Collects one ballot per voter over a valid/ready stream and presents the
// packed ballot vector downstream, then clears itself for the next round.
module ballot_collector #(
  parameter int N = 2,
  parameter int M = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [M-1:0]           in_voter,
  input  logic [N-1:0]           in_vote,
  input  logic                   close,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [(2**M)*N-1:0]    out_ballots,
  output logic [2**M-1:0]        out_cast,
  output logic [M:0]             out_count,
  output logic                   dup_err
);

  localparam int          SLOTS    = 2**M;
  localparam logic [M:0]  FULL_CNT = {1'b1, {M{1'b0}}};
  localparam logic [M:0]  ONE_CNT  = {{M{1'b0}}, 1'b1};

  typedef enum logic {
    COLLECT = 1'b0,
    PRESENT = 1'b1
  } state_t;

  state_t                 state, state_nx;
  logic [SLOTS*N-1:0]     ballots_nx;
  logic [SLOTS-1:0]       cast_nx;
  logic [M:0]             count_nx;
  logic                   dup_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= COLLECT;
    end else begin
      state <= state_nx;
    end
  end

  // Round storage: reset must discard collected ballots immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_ballots <= '0;
      out_cast    <= '0;
      out_count   <= '0;
      dup_err     <= 1'b0;
    end else begin
      out_ballots <= ballots_nx;
      out_cast    <= cast_nx;
      out_count   <= count_nx;
      dup_err     <= dup_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    ballots_nx = out_ballots;
    cast_nx    = out_cast;
    count_nx   = out_count;
    dup_nx     = 1'b0;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      COLLECT: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (!out_cast[in_voter]) begin
            ballots_nx[int'(in_voter)*N +: N] = in_vote;
            cast_nx[in_voter]                 = 1'b1;
            count_nx                          = out_count + ONE_CNT;
          end else begin
            dup_nx = 1'b1;
          end
        end
        // The close decision sees the count including this cycle's ballot.
        if (count_nx == FULL_CNT) begin
          state_nx = PRESENT;
        end else if (close && (count_nx != '0)) begin
          state_nx = PRESENT;
        end
      end
      PRESENT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nx   = COLLECT;
          ballots_nx = '0;
          cast_nx    = '0;
          count_nx   = '0;
        end
      end
      default: state_nx = COLLECT;
    endcase
  end

endmodule
